// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 8-bit combinational ALU.
// Buffers {acc_sel, x, a, b} commands in a small FIFO. Each command is issued
// on registered ALU inputs, and the result is captured one cycle later. That
// result is presented on a valid/ready channel and also feeds the accumulator.
module alu_cmd_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [3:0]                 cmd_x,
   input  logic [7:0]                 cmd_a,
   input  logic [7:0]                 cmd_b,
   input  logic                       cmd_acc,
   input  logic                       acc_clr,
   output logic [7:0]                 alu_a,
   output logic [7:0]                 alu_b,
   output logic [3:0]                 alu_x,
   input  logic [7:0]                 alu_op,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [7:0]                 res_data,
   output logic                       res_zero,
   output logic                       res_dz,
   output logic [7:0]                 acc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_MOD = 4'b0100;

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   typedef struct packed {
      logic       acc_sel;
      logic [3:0] x;
      logic [7:0] a;
      logic [7:0] b;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          entry_in;
   entry_t          head;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push, pop;

   state_t          state_q, state_d;
   logic [7:0]      alu_a_q, alu_a_d;
   logic [7:0]      alu_b_q, alu_b_d;
   logic [3:0]      alu_x_q, alu_x_d;
   logic            res_valid_q, res_valid_d;
   logic [7:0]      res_data_q, res_data_d;
   logic            res_zero_q, res_zero_d;
   logic            res_dz_q, res_dz_d;
   logic [7:0]      acc_q, acc_d;
   logic            div_zero;

   assign entry_in  = {cmd_acc, cmd_x, cmd_a, cmd_b};
   assign head      = mem_q[rd_ptr_q];
   assign cmd_ready = (count_q < CW'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   // The only pop is an issue from IDLE; it must match the FSM's issue decision.
   assign pop       = (state_q == IDLE) && (count_q != '0);
   assign div_zero  = ((alu_x_q == OP_DIV) || (alu_x_q == OP_MOD)) && (alu_b_q == 8'h00);

   // FIFO storage write.
   // NOTE: the storage array has no reset; count gates every read, so stale
   // contents are never observed, and leaving it unreset keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= entry_in;
   end

   // FIFO pointer and occupancy next-state. Pointers wrap naturally at DEPTH (a power of 2).
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // so no path can leave one unassigned and infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Issue / capture / hold FSM with its registered datapath.
   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_x_d     = alu_x_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_zero_d  = res_zero_q;
      res_dz_d    = res_dz_q;
      acc_d       = acc_q;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               alu_x_d = head.x;
               alu_b_d = head.b;
               alu_a_d = head.acc_sel ? acc_q : head.a;
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_valid_d = 1'b1;
            if (div_zero) begin
               // The ALU output is meaningless here; flag it and keep acc.
               res_data_d = 8'hFF;
               res_zero_d = 1'b0;
               res_dz_d   = 1'b1;
            end else begin
               res_data_d = alu_op;
               res_zero_d = (alu_op == 8'h00);
               res_dz_d   = 1'b0;
               acc_d      = alu_op;
            end
            state_d = HOLD;
         end
         HOLD: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // The clear takes priority over a same-cycle capture into acc.
      if (acc_clr) acc_d = 8'h00;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state always uses non-blocking assignment so every
         // flop samples its _d value from before the edge.
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         alu_a_q     <= 8'h00;
         alu_b_q     <= 8'h00;
         alu_x_q     <= 4'h0;
         res_valid_q <= 1'b0;
         res_data_q  <= 8'h00;
         res_zero_q  <= 1'b0;
         res_dz_q    <= 1'b0;
         acc_q       <= 8'h00;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_x_q     <= alu_x_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_zero_q  <= res_zero_d;
         res_dz_q    <= res_dz_d;
         acc_q       <= acc_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_x     = alu_x_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_zero  = res_zero_q;
   assign res_dz    = res_dz_q;
   assign acc       = acc_q;
   assign count     = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer.
// It supplies the combinational ALU. Accepted commands push the expected result
// into a scoreboard queue, and a monitor pops from it on every result handshake.
module tb_alu_cmd_sequencer;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_acc, acc_clr;
   logic [3:0] cmd_x, alu_x;
   logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_op;
   logic       res_valid, res_ready, res_zero, res_dz;
   logic [7:0] res_data, acc;
   logic [2:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] data;
      logic       zero;
      logic       dz;
      logic [7:0] acc;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] model_acc   = 8'h00;
   bit         clr_pending = 1'b0;
   bit         rand_rr     = 1'b0;

   always #5 clk = ~clk;

   // Behavioural 8-bit ALU (the design's downstream neighbour).
   function automatic logic [7:0] alu_f(input logic [3:0] x, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      case (x)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a * b;
         4'd3:    r = (b == 0) ? 8'h00 : a / b;
         4'd4:    r = (b == 0) ? 8'h00 : a % b;
         4'd5:    r = a & b;
         4'd6:    r = a | b;
         4'd7:    r = a ^ b;
         4'd8:    r = ~a;
         4'd9:    r = a << b[2:0];
         4'd10:   r = a >> b[2:0];
         4'd11:   r = ~(a & b);
         4'd12:   r = ~(a | b);
         4'd13:   r = ~(a ^ b);
         4'd14:   r = a + 8'd1;
         default: r = a - 8'd1;
      endcase
      return r;
   endfunction

   assign alu_op = alu_f(alu_x, alu_a, alu_b);

   alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
      .acc_clr(acc_clr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x), .alu_op(alu_op),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_zero(res_zero), .res_dz(res_dz),
      .acc(acc), .count(count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: score result handshakes, and record the reference result of each accepted command.
   exp_t       mon_e;
   logic [7:0] mon_a, mon_r;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
               check("result_without_command", 32'(res_valid), 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               check("res_data", 32'(res_data), 32'(mon_e.data));
               check("res_zero", 32'(res_zero), 32'(mon_e.zero));
               check("res_dz",   32'(res_dz),   32'(mon_e.dz));
               check("acc",      32'(acc),      32'(mon_e.acc));
            end
         end
         if (cmd_valid && cmd_ready) begin
            mon_a = cmd_acc ? model_acc : cmd_a;
            if ((cmd_x == 4'd3 || cmd_x == 4'd4) && cmd_b == 8'h00) begin
               if (clr_pending) model_acc = 8'h00;
               mon_e = '{data: 8'hFF, zero: 1'b0, dz: 1'b1, acc: model_acc};
            end else begin
               mon_r     = alu_f(cmd_x, mon_a, cmd_b);
               model_acc = clr_pending ? 8'h00 : mon_r;
               mon_e     = '{data: mon_r, zero: (mon_r == 8'h00), dz: 1'b0, acc: model_acc};
            end
            clr_pending = 1'b0;
            sb_q.push_back(mon_e);
         end
      end
   end

   // Random backpressure during the random phase.
   always @(posedge clk) begin
      if (rand_rr) begin
         #1;
         res_ready = 1'($urandom_range(0, 1));
      end
   end

   // Present a command and wait (bounded) until it is accepted; returns at edge+1.
   task automatic send(input logic [3:0] x, input logic [7:0] a, input logic [7:0] b,
                       input logic sel, input bit keep);
      bit got = 1'b0;
      int budget = 0;
      cmd_x = x; cmd_a = a; cmd_b = b; cmd_acc = sel; cmd_valid = 1'b1;
      while (!got && budget < 300) begin
         @(negedge clk);
         got = cmd_ready;
         @(posedge clk);
         #1;
         budget++;
      end
      check("cmd_accepted", 32'(got), 32'd1);
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int budget = 0;
      while (sb_q.size() != 0 && budget < 600) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check({"drain_", name}, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_valid = 1'b0; cmd_x = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_acc = 1'b0;
      acc_clr = 1'b0; res_ready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #12;
      // Reset state.
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_count",     32'(count),     32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_acc",       32'(acc),       32'd0);
      check("rst_alu_a",     32'(alu_a),     32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single add with latency check.
      res_ready = 1'b1;
      send(4'd0, 8'd5, 8'd3, 1'b0, 1'b0);
      check("lat_e0_valid", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_e1_valid", 32'(res_valid), 32'd0);
      check("issue_alu_a",  32'(alu_a), 32'd5);
      check("issue_alu_b",  32'(alu_b), 32'd3);
      check("issue_alu_x",  32'(alu_x), 32'd0);
      @(posedge clk); #1;
      check("lat_e2_valid", 32'(res_valid), 32'd1);
      check("add_res",      32'(res_data), 32'd8);
      check("add_acc",      32'(acc), 32'd8);
      drain("single_add");

      // Accumulator chain: 10, 11, 33, 0.
      send(4'd0,  8'd10, 8'd0,  1'b0, 1'b1);
      send(4'd14, 8'd0,  8'd0,  1'b1, 1'b1);
      send(4'd2,  8'd0,  8'd3,  1'b1, 1'b1);
      send(4'd1,  8'd0,  8'd33, 1'b1, 1'b0);
      drain("chain");
      check("chain_final_acc", 32'(acc), 32'd0);

      // Full FIFO under backpressure.
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(4'd0, 8'(i * 16 + 1), 8'(i), 1'b0, 1'b1);
      cmd_x = 4'd7; cmd_a = 8'hC3; cmd_b = 8'h3C; cmd_acc = 1'b0;
      @(negedge clk);
      check("full_count",     32'(count),     32'd4);
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      check("full_first_issued_a", 32'(alu_a), 32'd1);
      @(posedge clk); #1;
      res_ready = 1'b1;
      send(4'd7, 8'hC3, 8'h3C, 1'b0, 1'b0);
      drain("full_fifo");

      // Divide and modulo by zero.
      send(4'd0, 8'd7, 8'd0, 1'b0, 1'b0);
      drain("preload");
      send(4'd3, 8'd9, 8'd0, 1'b0, 1'b0);
      drain("div_zero");
      check("dz_acc_kept", 32'(acc), 32'd7);
      send(4'd4, 8'd9, 8'd0, 1'b0, 1'b0);
      send(4'd3, 8'd9, 8'd2, 1'b0, 1'b0);
      drain("div_ok");

      // Backpressure stability.
      res_ready = 1'b0;
      send(4'd7, 8'h5A, 8'h0F, 1'b0, 1'b0);
      for (int i = 0; i < 10 && !res_valid; i++) begin @(posedge clk); #1; end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(res_valid), 32'd1);
         check("bp_data",  32'(res_data),  32'h55);
      end
      res_ready = 1'b1;
      drain("backpressure");

      // acc_clr coinciding with the EXEC capture.
      clr_pending = 1'b1;
      send(4'd0, 8'd20, 8'd22, 1'b0, 1'b0);
      @(posedge clk); #1 acc_clr = 1'b1;
      @(posedge clk); #1 acc_clr = 1'b0;
      check("clr_acc",      32'(acc),      32'd0);
      check("clr_res_data", 32'(res_data), 32'd42);
      drain("acc_clr");

      // Reset while EXEC with two commands queued.
      res_ready = 1'b0;
      send(4'd0, 8'd1, 8'd1, 1'b0, 1'b1);
      send(4'd0, 8'd2, 8'd2, 1'b0, 1'b1);
      send(4'd0, 8'd3, 8'd3, 1'b0, 1'b1);
      send(4'd0, 8'd4, 8'd4, 1'b0, 1'b0);
      res_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("pre_reset_count", 32'(count), 32'd2);
      check("pre_reset_alu_a", 32'(alu_a), 32'd2);
      #1 rst_n = 1'b0;
      #1;
      sb_q.delete();
      model_acc = 8'h00;
      check("mid_rst_count",     32'(count),     32'd0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_res_valid", 32'(res_valid), 32'd0);
      check("mid_rst_res_data",  32'(res_data),  32'd0);
      check("mid_rst_alu_a",     32'(alu_a),     32'd0);
      check("mid_rst_alu_x",     32'(alu_x),     32'd0);
      check("mid_rst_acc",       32'(acc),       32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("post_rst_no_valid", 32'(res_valid), 32'd0);
         check("post_rst_count",    32'(count),     32'd0);
      end

      // Randomized commands with random backpressure.
      rand_rr = 1'b1;
      for (int i = 0; i < 150; i++) begin
         int n_idle;
         logic [7:0] rb;
         n_idle = $urandom_range(0, 2);
         if (n_idle > 0) begin
            cmd_valid = 1'b0;
            repeat (n_idle) begin @(posedge clk); #1; end
         end
         rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         send(4'($urandom_range(0, 15)), 8'($urandom), rb, 1'($urandom_range(0, 1)), 1'b1);
      end
      cmd_valid = 1'b0;
      @(posedge clk); #1 rand_rr = 1'b0;
      @(posedge clk); #2 res_ready = 1'b1;
      drain("random");
      @(posedge clk); #1;
      check("final_count", 32'(count), 32'd0);
      check("final_res_valid", 32'(res_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
